// File: rtl/batting_pkg.sv
// ---------------------------------------------------------------------------
// batting_pkg
//
// Shared definitions for the batting roulette wheel:
//   - outcome code constants (OUT, SINGLE, DOUBLE, TRIPLE, HOMERUN)
//   - wheel FSM state enum and pacer mode enum
//   - DEFAULT_MAP, the 13-slot outcome ring used by the classic game
//   - hitout_of(), the code -> one-hot {hit1,hit2,hit3,hit4,out} decode
// ---------------------------------------------------------------------------
package batting_pkg;

  // Outcome codes stored in each 3-bit slot of the map.
  localparam logic [2:0] CODE_OUT     = 3'd0;
  localparam logic [2:0] CODE_SINGLE  = 3'd1;
  localparam logic [2:0] CODE_DOUBLE  = 3'd2;
  localparam logic [2:0] CODE_TRIPLE  = 3'd3;
  localparam logic [2:0] CODE_HOMERUN = 3'd4;

  // Wheel control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPIN  = 2'd1,
    COAST = 2'd2,
    HOLD  = 2'd3
  } wheel_state_e;

  // What the pacer is timing: nothing, steady spin, or deceleration.
  typedef enum logic [1:0] {
    PACE_HALT  = 2'd0,
    PACE_SPIN  = 2'd1,
    PACE_COAST = 2'd2
  } pace_mode_e;

  // Slots 0..12, slot i at bits [3i+2:3i]; listed here from slot 12 down.
  localparam logic [38:0] DEFAULT_MAP = {
    CODE_OUT,      // 12
    CODE_HOMERUN,  // 11
    CODE_DOUBLE,   // 10
    CODE_TRIPLE,   //  9
    CODE_OUT,      //  8
    CODE_OUT,      //  7
    CODE_OUT,      //  6
    CODE_OUT,      //  5
    CODE_OUT,      //  4
    CODE_SINGLE,   //  3
    CODE_OUT,      //  2
    CODE_OUT,      //  1
    CODE_OUT       //  0
  };

  // One-hot {hit1,hit2,hit3,hit4,out}; unused codes 5..7 decode to nothing.
  function automatic logic [4:0] hitout_of(input logic [2:0] code);
    logic [4:0] onehot;
    case (code)
      CODE_OUT:     onehot = 5'b00001;
      CODE_SINGLE:  onehot = 5'b10000;
      CODE_DOUBLE:  onehot = 5'b01000;
      CODE_TRIPLE:  onehot = 5'b00100;
      CODE_HOMERUN: onehot = 5'b00010;
      default:      onehot = 5'b00000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/batting_pacer.sv
// ---------------------------------------------------------------------------
// batting_pacer
//
// Timing engine for the wheel. Counts clock cycles between slot advances:
//   PACE_SPIN  : one advance every PRESCALE cycles
//   PACE_COAST : step k advances after PRESCALE*(k+2) cycles, k = 0,1,...
//   PACE_HALT  : counter frozen, no advances
// A clear zeroes both the pace counter and the coast step counter; it takes
// priority over counting but does not suppress an advance due that cycle.
//
// Parameters:
//   PRESCALE     cycles per slot advance while spinning (>=1)
//   COAST_STEPS  number of advances after release (1..15)
// Ports:
//   clk         clock
//   reset       synchronous, active-high
//   mode        pace_mode_e, selects spin/coast timing or halt
//   clear       zero pace counter and coast step
//   advance     one-cycle strobe: the wheel moves one slot on this edge
//   coast_done  one-cycle strobe: this advance is the final coast step
// ---------------------------------------------------------------------------
module batting_pacer
  import batting_pkg::*;
#(
  parameter int PRESCALE    = 1,
  parameter int COAST_STEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  pace_mode_e mode,
  input  logic       clear,
  output logic       advance,
  output logic       coast_done
);

  // Longest interval is the last coast step: PRESCALE*(COAST_STEPS+1).
  localparam int MAX_WAIT = PRESCALE * (COAST_STEPS + 1);
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] pace_cnt;
  logic [CNT_W-1:0] limit;
  logic [3:0]       step_k;
  logic             last_step;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    limit      = '0;
    advance    = 1'b0;
    coast_done = 1'b0;
    last_step  = (step_k == 4'(COAST_STEPS - 1));
    case (mode)
      PACE_SPIN:  limit = CNT_W'(PRESCALE - 1);
      PACE_COAST: limit = CNT_W'(PRESCALE * (int'(step_k) + 2) - 1);
      default:    limit = '0;
    endcase
    advance    = (mode != PACE_HALT) && (pace_cnt == limit);
    coast_done = (mode == PACE_COAST) && advance && last_step;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pace_cnt <= '0;
      step_k   <= '0;
    end else if (advance) begin
      pace_cnt <= '0;
      if (mode == PACE_COAST) begin
        step_k <= last_step ? 4'd0 : step_k + 4'd1;
      end
    end else if (mode != PACE_HALT) begin
      pace_cnt <= pace_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/batting_wheel.sv
// ---------------------------------------------------------------------------
// batting_wheel
//
// Batting roulette wheel. A ring of NUM_SLOTS outcome slots rotates while
// spin is held, decelerates through COAST_STEPS slowing steps after release,
// then offers the landed outcome on a valid/ready handshake.
//
// Parameters:
//   NUM_SLOTS    number of slots (2..64)
//   SLOT_MAP     NUM_SLOTS x 3-bit outcome codes, slot i at [3i+2:3i]
//                (the default suits NUM_SLOTS=13; other sizes pass a map)
//   PRESCALE     cycles per slot advance while spinning (>=1)
//   COAST_STEPS  slot advances after release (1..15)
// Ports:
//   clk           clock
//   reset         synchronous, active-high
//   spin          level, high = wheel spinning
//   result_ready  consumer accepts the result
//   result_valid  landed result available (HOLD)
//   result_code   outcome code of the current slot
//   slot_idx      current slot
//   hitout        one-hot {hit1,hit2,hit3,hit4,out} of the current slot
//   busy          wheel is in SPIN or COAST
//   hits_total    (BATTING_WHEEL_STATS_EN only) accepted hits, saturating
//   outs_total    (BATTING_WHEEL_STATS_EN only) accepted outs, saturating
//
// Build option: define BATTING_WHEEL_STATS_EN to add the result counters.
// All outputs are registered; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module batting_wheel
  import batting_pkg::*;
#(
  parameter int                     NUM_SLOTS   = 13,
  parameter logic [3*NUM_SLOTS-1:0] SLOT_MAP    = DEFAULT_MAP,
  parameter int                     PRESCALE    = 1,
  parameter int                     COAST_STEPS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spin,
  input  logic                         result_ready,
  output logic                         result_valid,
  output logic [2:0]                   result_code,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
  output logic [4:0]                   hitout,
  output logic                         busy
`ifdef BATTING_WHEEL_STATS_EN
  ,
  output logic [7:0]                   hits_total,
  output logic [7:0]                   outs_total
`endif
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  wheel_state_e      state;
  pace_mode_e        mode;
  logic              clear;
  logic              advance;
  logic              coast_done;
  logic              xfer;
  logic [SLOT_W-1:0] slot_next;
  logic [2:0]        code_next;

  // Pacer control: it runs only in SPIN/COAST. Clearing in IDLE keeps it
  // primed, and clearing on the release edge starts the coast from k=0.
  always_comb begin
    mode  = PACE_HALT;
    clear = 1'b0;
    case (state)
      IDLE:    clear = 1'b1;
      SPIN: begin
        mode  = PACE_SPIN;
        clear = !spin;
      end
      COAST:   mode = PACE_COAST;
      default: mode = PACE_HALT;
    endcase
  end

  batting_pacer #(
    .PRESCALE    (PRESCALE),
    .COAST_STEPS (COAST_STEPS)
  ) u_pacer (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .clear      (clear),
    .advance    (advance),
    .coast_done (coast_done)
  );

  // Next slot on the ring and its code, so the decode can be registered on
  // the same edge as slot_idx.
  always_comb begin
    slot_next = (slot_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_idx + 1'b1;
    code_next = SLOT_MAP[3*int'(slot_next) +: 3];
  end

  assign xfer = result_valid && result_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      slot_idx     <= '0;
      result_code  <= SLOT_MAP[2:0];
      hitout       <= hitout_of(SLOT_MAP[2:0]);
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // The pacer only advances in SPIN/COAST, so HOLD keeps the slot frozen.
      if (advance) begin
        slot_idx    <= slot_next;
        result_code <= code_next;
        hitout      <= hitout_of(code_next);
      end

      case (state)
        IDLE: begin
          if (spin) begin
            state <= SPIN;
            busy  <= 1'b1;
          end
        end
        SPIN: begin
          if (!spin) begin
            state <= COAST;
          end
        end
        COAST: begin
          // Valid rises together with the final coast advance.
          if (coast_done) begin
            state        <= HOLD;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (xfer) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BATTING_WHEEL_STATS_EN
  // Tally accepted results; codes 5..7 count as neither hit nor out.
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_total <= 8'd0;
      outs_total <= 8'd0;
    end else if (xfer) begin
      if (result_code == CODE_OUT) begin
        if (outs_total != 8'hFF) outs_total <= outs_total + 8'd1;
      end else if (result_code <= CODE_HOMERUN) begin
        if (hits_total != 8'hFF) hits_total <= hits_total + 8'd1;
      end
    end
  end
`else
  // Result counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_batting_wheel.sv
// ---------------------------------------------------------------------------
// tb_batting_wheel
//
// Two wheels share the clock: dut_a with default parameters and dut_b with
// PRESCALE=3, COAST_STEPS=2. The reference model predicts the landing slot
// from arithmetic: spin held H cycles gives floor(H/PRESCALE) advances, the
// coast adds COAST_STEPS more and lasts PRESCALE*sum(k+2) cycles.
// ---------------------------------------------------------------------------
module tb_batting_wheel;
  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] spin;
  logic [1:0] ready;

  logic       valid_a, valid_b, busy_a, busy_b;
  logic [2:0] code_a, code_b;
  logic [3:0] slot_a, slot_b;
  logic [4:0] hit_a, hit_b;
`ifdef BATTING_WHEEL_STATS_EN
  logic [7:0] hits_a, outs_a, hits_b, outs_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Classic map, slot 0 first.
  int map_c [13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 2, 4, 0};
  int cur    [2];
  int hits_m [2];
  int outs_m [2];

  always #5 clk = ~clk;

  batting_wheel dut_a (
    .clk          (clk),
    .reset        (rst[0]),
    .spin         (spin[0]),
    .result_ready (ready[0]),
    .result_valid (valid_a),
    .result_code  (code_a),
    .slot_idx     (slot_a),
    .hitout       (hit_a),
    .busy         (busy_a)
`ifdef BATTING_WHEEL_STATS_EN
    ,
    .hits_total   (hits_a),
    .outs_total   (outs_a)
`endif
  );

  batting_wheel #(
    .PRESCALE    (3),
    .COAST_STEPS (2)
  ) dut_b (
    .clk          (clk),
    .reset        (rst[1]),
    .spin         (spin[1]),
    .result_ready (ready[1]),
    .result_valid (valid_b),
    .result_code  (code_b),
    .slot_idx     (slot_b),
    .hitout       (hit_b),
    .busy         (busy_b)
`ifdef BATTING_WHEEL_STATS_EN
    ,
    .hits_total   (hits_b),
    .outs_total   (outs_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int prescale_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic int steps_of(input int d);
    return (d == 1) ? 2 : 4;
  endfunction

  function automatic int coast_len(input int d);
    int total = 0;
    for (int k = 0; k < steps_of(d); k++) total += prescale_of(d) * (k + 2);
    return total;
  endfunction

  // Outcome table: out -> bit0, single..homerun -> bits 4..1.
  function automatic logic [4:0] ref_hitout(input int code);
    if (code == 0) return 5'b00001;
    if (code <= 4) return 5'b10000 >> (code - 1);
    return 5'b00000;
  endfunction

  function automatic logic [3:0] slot_of(input int d);
    return d ? slot_b : slot_a;
  endfunction
  function automatic logic [2:0] code_of(input int d);
    return d ? code_b : code_a;
  endfunction
  function automatic logic [4:0] hit_of(input int d);
    return d ? hit_b : hit_a;
  endfunction
  function automatic logic valid_of(input int d);
    return d ? valid_b : valid_a;
  endfunction
  function automatic logic busy_of(input int d);
    return d ? busy_b : busy_a;
  endfunction

  task automatic check_idle_reset(input int d);
    check("rst_slot",  slot_of(d),  0);
    check("rst_code",  code_of(d),  map_c[0]);
    check("rst_hit",   hit_of(d),   ref_hitout(map_c[0]));
    check("rst_valid", valid_of(d), 0);
    check("rst_busy",  busy_of(d),  0);
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
    cur[d] = 0;
  endtask

  task automatic account(input int d, input int code);
    if (code == 0) begin
      if (outs_m[d] < 255) outs_m[d]++;
    end else if (code <= 4) begin
      if (hits_m[d] < 255) hits_m[d]++;
    end
`ifdef BATTING_WHEEL_STATS_EN
    check("hits_total", d ? hits_b : hits_a, hits_m[d]);
    check("outs_total", d ? outs_b : outs_a, outs_m[d]);
`endif
  endtask

  // Spin H cycles, coast, land. lag<0: ready already high at landing;
  // otherwise ready stays low for lag HOLD cycles with spin noise first.
  task automatic land(input int d, input int h, input int lag);
    int after_spin, fin, code;
    after_spin = (cur[d] + h / prescale_of(d)) % 13;
    fin        = (after_spin + steps_of(d)) % 13;
    code       = map_c[fin];
    spin[d] = 1'b1;
    repeat (h) tick();
    spin[d] = 1'b0;
    if (lag < 0) ready[d] = 1'b1;
    tick();
    check("spin_slot",  slot_of(d),  after_spin);
    check("spin_busy",  busy_of(d),  1);
    check("spin_valid", valid_of(d), 0);
    for (int i = 0; i < coast_len(d) - 1; i++) begin
      spin[d] = 1'($urandom_range(0, 1));
      tick();
    end
    spin[d] = 1'b0;
    check("pre_land_valid", valid_of(d), 0);
    check("pre_land_slot",  slot_of(d), (fin + 12) % 13);
    tick();
    check("land_valid", valid_of(d), 1);
    check("land_busy",  busy_of(d),  0);
    check("land_slot",  slot_of(d),  fin);
    check("land_code",  code_of(d),  code);
    check("land_hit",   hit_of(d),   ref_hitout(code));
    if (lag >= 0) begin
      for (int i = 0; i < lag; i++) begin
        spin[d] = 1'($urandom_range(0, 1));
        tick();
        check("hold_valid", valid_of(d), 1);
        check("hold_slot",  slot_of(d),  fin);
      end
      spin[d]  = 1'b0;
      ready[d] = 1'b1;
    end
    tick();
    ready[d] = 1'b0;
    check("xfer_valid", valid_of(d), 0);
    check("xfer_busy",  busy_of(d),  0);
    account(d, code);
    tick();
    check("idle_valid", valid_of(d), 0);
    check("idle_slot",  slot_of(d),  fin);
    cur[d] = fin;
  endtask

  initial begin
    int h;
    rst   = 2'b11;
    spin  = 2'b11;
    ready = 2'b00;
    cur    = '{0, 0};
    hits_m = '{0, 0};
    outs_m = '{0, 0};
    repeat (3) tick();
    check_idle_reset(0);
    check_idle_reset(1);
    rst  = 2'b00;
    spin = 2'b00;
    tick();
    check("post_rst_slot", slot_a, 0);

    // Default wheel: 6 cycles of spin, backpressure for 5 HOLD cycles.
    land(0, 6, 5);
    // Wrap: restart from slot 0, 12 cycles, ready already high.
    do_reset(0);
    land(0, 12, -1);
    // Land on slot 0 (OUT) from slot 3.
    land(0, 6, 1);

    // Slow wheel: 9 cycles of spin, then mid-coast reset.
    land(1, 9, 2);
    spin[1] = 1'b1;
    repeat (9) tick();
    spin[1] = 1'b0;
    tick();
    repeat (4) tick();
    check("mid_coast_slot", slot_b, (cur[1] + 3) % 13);
    check("mid_coast_busy", busy_b, 1);
    rst[1] = 1'b1;
    tick();
    check_idle_reset(1);
    rst[1] = 1'b0;
    cur[1] = 0;
    tick();

    // Randomised landings on both wheels.
    for (int i = 0; i < 10; i++) begin
      land(0, $urandom_range(1, 30), int'($urandom_range(0, 5)) - 1);
      land(1, $urandom_range(1, 30), int'($urandom_range(0, 5)) - 1);
    end

`ifdef BATTING_WHEEL_STATS_EN
    // Drive hits past 255 by landing on slot 3 (SINGLE) repeatedly.
    for (int i = 0; i < 256; i++) begin
      h = ((3 - cur[0] - 4) % 13 + 13) % 13;
      if (h == 0) h = 13;
      land(0, h, -1);
    end
    check("hits_saturated", hits_a, 255);
`else
    h = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
